// File: rtl/jb_prach_nco_delay_align.sv
// Programmable-latency alignment delay for the TDM antenna-interleaved PRACH FFT stream.
// Optional antenna-sequence checker enabled by defining JB_NCO_ALIGN_SEQ_CHK_EN.
module jb_prach_nco_delay_align #(
  parameter int unsigned N_ANTENNAS  = 4,
  parameter int unsigned PRECISION   = 16,
  parameter int unsigned MAX_LATENCY = 15,
  parameter int unsigned LAT_RESET   = 2,
  localparam int unsigned USER_ID_BW = (N_ANTENNAS > 1) ? $clog2(N_ANTENNAS) : 1,
  localparam int unsigned LAT_BW     = $clog2(MAX_LATENCY + 1),
  localparam int unsigned DW         = 2 * PRECISION
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clk_en,
  input  logic                  tvalid_in,
  input  logic [DW-1:0]         tdata_in,
  input  logic [USER_ID_BW-1:0] tuser_in,
  input  logic                  tlast_in,
  input  logic [LAT_BW-1:0]     lat_cfg,
  input  logic                  lat_load,
  input  logic                  err_clr,
  output logic                  tvalid_out,
  output logic [DW-1:0]         tdata_out,
  output logic [USER_ID_BW-1:0] tuser_out,
  output logic                  tlast_out,
  output logic [LAT_BW-1:0]     lat_act,
  output logic                  lat_busy,
  output logic                  seq_err
);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e              state_q, state_d;
  logic [LAT_BW-1:0]   lat_q, lat_d;
  logic [LAT_BW-1:0]   cnt_q, cnt_d;
  logic                blank_q, blank_d;
  logic [LAT_BW-1:0]   lat_req;

  logic [MAX_LATENCY:0]  vld_q;
  logic [MAX_LATENCY:0]  last_q;
  logic [DW-1:0]         data_q [MAX_LATENCY+1];
  logic [USER_ID_BW-1:0] user_q [MAX_LATENCY+1];

  // Delay line: stage 0 captures the input, every stage shifts on each enabled cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int k = 0; k <= int'(MAX_LATENCY); k++) begin
        data_q[k] <= '0;
        user_q[k] <= '0;
      end
    end else if (clk_en) begin
      vld_q     <= {vld_q[MAX_LATENCY-1:0], tvalid_in};
      last_q    <= {last_q[MAX_LATENCY-1:0], tlast_in};
      data_q[0] <= tdata_in;
      user_q[0] <= tuser_in;
      for (int k = 1; k <= int'(MAX_LATENCY); k++) begin
        data_q[k] <= data_q[k-1];
        user_q[k] <= user_q[k-1];
      end
    end
  end

  assign lat_req = (32'(lat_cfg) > MAX_LATENCY) ? LAT_BW'(MAX_LATENCY) : lat_cfg;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StRun;
      lat_q   <= LAT_BW'(LAT_RESET);
      cnt_q   <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
    end
  end

  // Next state. A decrease takes effect at once (skipped samples are dropped); an increase
  // blanks the output for N-L cycles so beats already emitted are not repeated.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    if (clk_en) begin
      unique case (state_q)
        StRun: begin
          if (lat_load) begin
            if (lat_req < lat_q) begin
              lat_d = lat_req;
            end else if (lat_req > lat_q) begin
              lat_d   = lat_req;
              cnt_d   = lat_req - lat_q;
              blank_d = 1'b1;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (cnt_q == LAT_BW'(1)) begin
            cnt_d   = '0;
            blank_d = 1'b0;
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - LAT_BW'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Outputs straight from the selected tap, only valid is masked.
  always_comb begin
    lat_busy   = (state_q == StHold);
    lat_act    = lat_q;
    tvalid_out = vld_q[lat_q] & ~blank_q;
    tdata_out  = data_q[lat_q];
    tuser_out  = user_q[lat_q];
    tlast_out  = last_q[lat_q];
  end

`ifdef JB_NCO_ALIGN_SEQ_CHK_EN
  localparam logic [USER_ID_BW-1:0] ID_LAST = USER_ID_BW'(N_ANTENNAS - 1);

  logic [USER_ID_BW-1:0] exp_id_q, exp_id_d;
  logic                  seq_err_q, seq_err_d;
  logic                  beat_err;

  // A new error overrides a simultaneous clear.
  always_comb begin
    exp_id_d  = exp_id_q;
    seq_err_d = seq_err_q;
    beat_err  = 1'b0;
    if (clk_en) begin
      if (err_clr) seq_err_d = 1'b0;
      if (tvalid_in) begin
        beat_err = (tuser_in != exp_id_q) | (tlast_in & (tuser_in != ID_LAST));
        if (beat_err) seq_err_d = 1'b1;
        exp_id_d = (tlast_in || tuser_in == ID_LAST) ? '0 : tuser_in + USER_ID_BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exp_id_q  <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_id_q  <= exp_id_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_jb_prach_nco_delay_align.sv
// Directed bench for jb_prach_nco_delay_align: table-driven ramp plus hand-written
// sequences for clk_en gating, latency changes, reset in HOLD and the sequence checker.
module tb_jb_prach_nco_delay_align;

`ifdef JB_NCO_ALIGN_SEQ_CHK_EN
  localparam logic SEQ = 1'b1;
`else
  localparam logic SEQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        clk_en;
  logic        tvalid_in;
  logic [31:0] tdata_in;
  logic [1:0]  tuser_in;
  logic        tlast_in;
  logic [3:0]  lat_cfg;
  logic        lat_load;
  logic        err_clr;
  logic        tvalid_out;
  logic [31:0] tdata_out;
  logic [1:0]  tuser_out;
  logic        tlast_out;
  logic [3:0]  lat_act;
  logic        lat_busy;
  logic        seq_err;

  int n_cmp = 0;
  int n_err = 0;

  jb_prach_nco_delay_align dut (
    .clk        (clk),
    .resetn     (resetn),
    .clk_en     (clk_en),
    .tvalid_in  (tvalid_in),
    .tdata_in   (tdata_in),
    .tuser_in   (tuser_in),
    .tlast_in   (tlast_in),
    .lat_cfg    (lat_cfg),
    .lat_load   (lat_load),
    .err_clr    (err_clr),
    .tvalid_out (tvalid_out),
    .tdata_out  (tdata_out),
    .tuser_out  (tuser_out),
    .tlast_out  (tlast_out),
    .lat_act    (lat_act),
    .lat_busy   (lat_busy),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic [1:0]  user;
    logic        last;
    logic        e_vld;
    logic [31:0] e_data;
    logic [1:0]  e_user;
    logic        e_last;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    tvalid_in = 1'b0;
    tdata_in  = '0;
    tuser_in  = '0;
    tlast_in  = 1'b0;
  endtask

  task automatic drive_beat(input int n);
    tvalid_in = 1'b1;
    tdata_in  = 32'hC000_0000 + 32'(n);
    tuser_in  = 2'(n % 4);
    tlast_in  = (n % 4 == 3);
  endtask

  task automatic chk_beat(input string nm, input int n);
    chk({nm, ".vld"}, 32'(tvalid_out), 32'd1);
    chk({nm, ".data"}, tdata_out, 32'hC000_0000 + 32'(n));
    chk({nm, ".user"}, 32'(tuser_out), 32'(n % 4));
    chk({nm, ".last"}, 32'(tlast_out), 32'(n % 4 == 3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int busy_cnt;

    // Ramp table at lat 2: beat r appears after edge r+2
    for (int r = 0; r < 11; r++) begin
      tbl[r].vld  = (r < 8);
      tbl[r].data = (r < 8) ? 32'hA000_0000 + 32'(r) : 32'h0;
      tbl[r].user = (r < 8) ? 2'(r % 4) : 2'd0;
      tbl[r].last = (r < 8) && (r % 4 == 3);
      if (r >= 2 && r - 2 < 8) begin
        tbl[r].e_vld  = 1'b1;
        tbl[r].e_data = 32'hA000_0000 + 32'(r - 2);
        tbl[r].e_user = 2'((r - 2) % 4);
        tbl[r].e_last = ((r - 2) % 4 == 3);
      end else begin
        tbl[r].e_vld  = 1'b0;
        tbl[r].e_data = '0;
        tbl[r].e_user = '0;
        tbl[r].e_last = 1'b0;
      end
    end

    // Reset with busy-looking inputs
    resetn    = 1'b0;
    clk_en    = 1'b1;
    tvalid_in = 1'b1;
    tdata_in  = 32'hFFFF_FFFF;
    tuser_in  = 2'd3;
    tlast_in  = 1'b1;
    lat_cfg   = 4'd9;
    lat_load  = 1'b1;
    err_clr   = 1'b0;
    tick();
    tick();
    chk("rst.vld", 32'(tvalid_out), 32'd0);
    chk("rst.data", tdata_out, 32'd0);
    chk("rst.user", 32'(tuser_out), 32'd0);
    chk("rst.last", 32'(tlast_out), 32'd0);
    chk("rst.lat_act", 32'(lat_act), 32'd2);
    chk("rst.busy", 32'(lat_busy), 32'd0);
    chk("rst.seq_err", 32'(seq_err), 32'd0);
    resetn   = 1'b1;
    lat_load = 1'b0;
    idle_in();

    for (int r = 0; r < 11; r++) begin
      tvalid_in = tbl[r].vld;
      tdata_in  = tbl[r].data;
      tuser_in  = tbl[r].user;
      tlast_in  = tbl[r].last;
      tick();
      chk($sformatf("ramp%0d.vld", r), 32'(tvalid_out), 32'(tbl[r].e_vld));
      chk($sformatf("ramp%0d.data", r), tdata_out, tbl[r].e_data);
      chk($sformatf("ramp%0d.user", r), 32'(tuser_out), 32'(tbl[r].e_user));
      chk($sformatf("ramp%0d.last", r), 32'(tlast_out), 32'(tbl[r].e_last));
      chk($sformatf("ramp%0d.lat", r), 32'(lat_act), 32'd2);
    end

    // clk_en at 50%: latency counted in enabled cycles, outputs hold otherwise
    for (int e = 0; e < 7; e++) begin
      logic        x_vld;
      logic [31:0] x_data;
      clk_en    = 1'b1;
      tvalid_in = (e < 5);
      tdata_in  = (e < 5) ? 32'hB000_0000 + 32'(e) : 32'h0;
      tuser_in  = (e < 5) ? 2'(e % 4) : 2'd0;
      tlast_in  = 1'b0;
      tick();
      x_vld  = (e >= 2);
      x_data = (e >= 2) ? 32'hB000_0000 + 32'(e - 2) : 32'h0;
      chk($sformatf("en%0d.vld", e), 32'(tvalid_out), 32'(x_vld));
      chk($sformatf("en%0d.data", e), tdata_out, x_data);
      clk_en    = 1'b0;
      tvalid_in = 1'b1;
      tdata_in  = 32'hDEAD_BEEF;
      tuser_in  = 2'd3;
      tlast_in  = 1'b1;
      lat_load  = (e == 3);
      lat_cfg   = 4'd9;
      tick();
      lat_load = 1'b0;
      chk($sformatf("dis%0d.vld", e), 32'(tvalid_out), 32'(x_vld));
      chk($sformatf("dis%0d.data", e), tdata_out, x_data);
      chk($sformatf("dis%0d.lat", e), 32'(lat_act), 32'd2);
    end
    clk_en = 1'b1;

    // Increase 2 -> 6 mid-stream; a second load during HOLD is ignored
    for (n = 0; n < 18; n++) begin
      drive_beat(n);
      lat_load = (n == 10) || (n == 11);
      lat_cfg  = (n == 10) ? 4'd6 : 4'd3;
      tick();
      lat_load = 1'b0;
      if (n >= 2 && n <= 9) begin
        chk_beat($sformatf("up%0d", n), n - 2);
        chk($sformatf("up%0d.busy", n), 32'(lat_busy), 32'd0);
      end else if (n >= 10 && n <= 13) begin
        chk($sformatf("hold%0d.vld", n), 32'(tvalid_out), 32'd0);
        chk($sformatf("hold%0d.busy", n), 32'(lat_busy), 32'd1);
        chk($sformatf("hold%0d.lat", n), 32'(lat_act), 32'd6);
      end else if (n >= 14) begin
        chk_beat($sformatf("post%0d", n), n - 6);
        chk($sformatf("post%0d.busy", n), 32'(lat_busy), 32'd0);
        chk($sformatf("post%0d.lat", n), 32'(lat_act), 32'd6);
      end
    end

    // Decrease 6 -> 5 (drops beat 12) then 5 -> 1 (drops beats 18..21), no blanking
    for (n = 18; n < 25; n++) begin
      drive_beat(n);
      lat_load = (n == 18) || (n == 23);
      lat_cfg  = (n == 18) ? 4'd5 : 4'd1;
      tick();
      lat_load = 1'b0;
      chk($sformatf("dn%0d.busy", n), 32'(lat_busy), 32'd0);
      if (n < 23) begin
        chk_beat($sformatf("dn%0d", n), n - 5);
        chk($sformatf("dn%0d.lat", n), 32'(lat_act), 32'd5);
      end else begin
        chk_beat($sformatf("dn%0d", n), n - 1);
        chk($sformatf("dn%0d.lat", n), 32'(lat_act), 32'd1);
      end
    end

    // Request all-ones (max) from lat 1: 14 blanked cycles, then beat 24 next
    drive_beat(25);
    lat_load = 1'b1;
    lat_cfg  = '1;
    tick();
    lat_load = 1'b0;
    chk("max.lat", 32'(lat_act), 32'd15);
    chk("max.busy", 32'(lat_busy), 32'd1);
    chk("max.vld", 32'(tvalid_out), 32'd0);
    busy_cnt = 1;
    n = 26;
    for (int c = 0; c < 40 && lat_busy; c++) begin
      drive_beat(n);
      tick();
      if (lat_busy) busy_cnt++;
      n++;
    end
    chk("max.busy_cycles", 32'(busy_cnt), 32'd14);
    chk("max.busy_end", 32'(lat_busy), 32'd0);
    chk_beat("max.resume", 24);

    // Reset in the middle of HOLD
    lat_load = 1'b1;
    lat_cfg  = 4'd3;
    tick();
    lat_cfg = 4'd12;
    tick();
    lat_load = 1'b0;
    chk("rhold.busy_pre", 32'(lat_busy), 32'd1);
    chk("rhold.lat_pre", 32'(lat_act), 32'd12);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    idle_in();
    chk("rhold.lat", 32'(lat_act), 32'd2);
    chk("rhold.busy", 32'(lat_busy), 32'd0);
    chk("rhold.vld", 32'(tvalid_out), 32'd0);
    chk("rhold.data", tdata_out, 32'd0);

    // Sequence checker: 0,1,3 errors on the id-3 beat
    tvalid_in = 1'b1;
    tuser_in  = 2'd0;
    tick();
    chk("seq.id0", 32'(seq_err), 32'd0);
    tuser_in = 2'd1;
    tick();
    chk("seq.id1", 32'(seq_err), 32'd0);
    tuser_in = 2'd3;
    tick();
    chk("seq.id3", 32'(seq_err), 32'(SEQ));
    idle_in();
    tick();
    tick();
    chk("seq.sticky", 32'(seq_err), 32'(SEQ));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("seq.clr", 32'(seq_err), 32'd0);
    // tlast on id 2 with otherwise correct order
    tvalid_in = 1'b1;
    tuser_in  = 2'd0;
    tick();
    tuser_in = 2'd1;
    tick();
    tuser_in = 2'd2;
    tlast_in = 1'b1;
    tick();
    chk("seq.early_last", 32'(seq_err), 32'(SEQ));
    tlast_in  = 1'b0;
    tvalid_in = 1'b0;
    err_clr   = 1'b1;
    tick();
    chk("seq.clr2", 32'(seq_err), 32'd0);
    // After tlast the expected id is 0: id 2 with err_clr, error wins
    tvalid_in = 1'b1;
    tuser_in  = 2'd2;
    tick();
    err_clr = 1'b0;
    idle_in();
    chk("seq.err_wins", 32'(seq_err), 32'(SEQ));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
